// File: rtl/imem_dmem_port_arbiter_if.sv
// imem_dmem_port_arbiter_if
//   Bundle of the three buses around the IF/DM memory port arbiter:
//   the instruction-fetch requester (if_*), the data-memory requester
//   (dm_*) and the shared unified memory (mem_*), plus the sticky
//   watchdog flag arb_timeout.
//   Modports:
//     slave  - the arbiter's view (takes requests, drives memory side)
//     master - the surrounding pipeline/memory view (drives requests)
interface imem_dmem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_stall;

  logic        dm_req;
  logic        dm_we;
  logic [2:0]  dm_func3;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        dm_err;
  logic        dm_stall;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        arb_timeout;

  modport slave (
    input  if_req, if_addr,
    output if_rdata, if_valid, if_stall,
    input  dm_req, dm_we, dm_func3, dm_addr, dm_wdata,
    output dm_rdata, dm_valid, dm_err, dm_stall,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack,
    output arb_timeout
  );

  modport master (
    output if_req, if_addr,
    input  if_rdata, if_valid, if_stall,
    output dm_req, dm_we, dm_func3, dm_addr, dm_wdata,
    input  dm_rdata, dm_valid, dm_err, dm_stall,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack,
    input  arb_timeout
  );
endinterface

// File: rtl/imem_dmem_port_arbiter.sv
// imem_dmem_port_arbiter
//   Shares one single-ported, variable-latency memory between the IF and
//   MEM pipeline stages. DM normally wins contention, but after
//   MAX_DM_BURST consecutive DM grants with IF waiting, IF gets the next
//   grant. Performs RV32 store lane steering and load sign/zero extension,
//   flags misaligned DM accesses without touching memory, and generates
//   per-requester stalls.
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous active-low reset
//     bus  - imem_dmem_port_arbiter_if.slave (if_*, dm_*, mem_*, arb_timeout)
//   Parameters:
//     MAX_DM_BURST - consecutive DM grants allowed while IF waits (1..15)
//     TIMEOUT      - memory-ack watchdog limit in BUSY cycles
//   Optional feature macro: ARB_TIMEOUT_EN (ack watchdog + sticky
//   arb_timeout flag); without it BUSY waits forever and arb_timeout = 0.
module imem_dmem_port_arbiter #(
  parameter int unsigned MAX_DM_BURST = 4,
  parameter int unsigned TIMEOUT      = 64
) (
  input logic                      clk,
  input logic                      rst,
  imem_dmem_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    DM_ERR  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  burst_cnt, burst_cnt_nxt;
  logic        dm_wins;
  logic        timeout_hit;

  // Access size decode. Stores only know sb/sh/sw; loads fold lbu/lhu onto
  // the byte/half sizes. Anything else is a word access.
  logic        dm_byte, dm_half, dm_signed, dm_misaligned;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata_st, dm_load;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    if (bus.dm_we) begin
      dm_byte = (bus.dm_func3 == 3'b000);
      dm_half = (bus.dm_func3 == 3'b001);
    end else begin
      dm_byte = (bus.dm_func3[1:0] == 2'b00);
      dm_half = (bus.dm_func3[1:0] == 2'b01);
    end
    dm_signed     = ~bus.dm_func3[2];
    dm_misaligned = (dm_half & bus.dm_addr[0]) |
                    (~dm_byte & ~dm_half & (bus.dm_addr[1:0] != 2'b00));

    if (dm_byte) begin
      dm_be       = 4'b0001 << bus.dm_addr[1:0];
      dm_wdata_st = {4{bus.dm_wdata[7:0]}};
    end else if (dm_half) begin
      dm_be       = 4'b0011 << bus.dm_addr[1:0];
      dm_wdata_st = {2{bus.dm_wdata[15:0]}};
    end else begin
      dm_be       = 4'hF;
      dm_wdata_st = bus.dm_wdata;
    end

    ld_byte = bus.mem_rdata[{bus.dm_addr[1:0], 3'b000} +: 8];
    ld_half = bus.dm_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    if (dm_byte)
      dm_load = {{24{dm_signed & ld_byte[7]}}, ld_byte};
    else if (dm_half)
      dm_load = {{16{dm_signed & ld_half[15]}}, ld_half};
    else
      dm_load = bus.mem_rdata;
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;
  logic          arb_timeout_q;

  assign timeout_hit = ((state == BUSY_IF) || (state == BUSY_DM)) &&
                       !bus.mem_ack && (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt       <= '0;
      arb_timeout_q <= 1'b0;
    end else begin
      // Counts only while staying in a BUSY state; any exit clears it.
      if (((state == BUSY_IF) || (state == BUSY_DM)) && (state_nxt == state))
        tmo_cnt <= tmo_cnt + 1'b1;
      else
        tmo_cnt <= '0;
      if (timeout_hit)
        arb_timeout_q <= 1'b1;
    end
  end

  assign bus.arb_timeout = arb_timeout_q;
`else
  assign timeout_hit     = 1'b0;
  assign bus.arb_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    burst_cnt_nxt = burst_cnt;
    dm_wins       = bus.dm_req &&
                    !(bus.if_req && (burst_cnt == 4'(MAX_DM_BURST)));

    bus.if_rdata  = '0;
    bus.if_valid  = 1'b0;
    bus.if_stall  = 1'b0;
    bus.dm_rdata  = '0;
    bus.dm_valid  = 1'b0;
    bus.dm_err    = 1'b0;
    bus.dm_stall  = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_be    = '0;
    bus.mem_wdata = '0;

    unique case (state)
      IDLE: begin
        if (dm_wins) begin
          state_nxt     = dm_misaligned ? DM_ERR : BUSY_DM;
          burst_cnt_nxt = bus.if_req ? burst_cnt + 4'd1 : '0;
        end else if (bus.if_req) begin
          state_nxt     = BUSY_IF;
          burst_cnt_nxt = '0;
        end
      end
      BUSY_IF: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {bus.if_addr[31:2], 2'b00};
        bus.mem_be   = 4'hF;
        if (bus.mem_ack || timeout_hit) begin
          bus.if_valid = 1'b1;
          bus.if_rdata = bus.mem_ack ? bus.mem_rdata : '0;
          state_nxt    = IDLE;
        end
      end
      BUSY_DM: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = bus.dm_we;
        bus.mem_addr  = {bus.dm_addr[31:2], 2'b00};
        bus.mem_be    = dm_be;
        bus.mem_wdata = dm_wdata_st;
        if (bus.mem_ack || timeout_hit) begin
          bus.dm_valid = 1'b1;
          bus.dm_rdata = bus.mem_ack ? dm_load : '0;
          bus.dm_err   = ~bus.mem_ack;
          state_nxt    = IDLE;
        end
      end
      DM_ERR: begin
        bus.dm_valid = 1'b1;
        bus.dm_err   = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    bus.if_stall = bus.if_req & ~bus.if_valid;
    bus.dm_stall = bus.dm_req & ~bus.dm_valid;

    // While reset is held every output is forced low, even if the state
    // register has not yet been cleared by the synchronous reset edge.
    if (!rst) begin
      bus.if_rdata  = '0;
      bus.if_valid  = 1'b0;
      bus.if_stall  = 1'b0;
      bus.dm_rdata  = '0;
      bus.dm_valid  = 1'b0;
      bus.dm_err    = 1'b0;
      bus.dm_stall  = 1'b0;
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_be    = '0;
      bus.mem_wdata = '0;
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.if_addr[1:0];

endmodule

// File: doc/imem_dmem_port_arbiter.md
Name: imem_dmem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the pipeline's instruction-fetch (IF) stage and its data-memory (MEM) stage.
- Arbitrates between the two requesters and sequences the memory handshake.
- Performs RV32 store byte-lane steering and load sign/zero extension from func3.
- Produces per-requester stall signals that the datapath uses to freeze its pipeline registers.

Parameters:
- MAX_DM_BURST, 4: maximum number of consecutive DM grants while IF is waiting; after that many, IF receives the next grant. Range 1..15.
- TIMEOUT, 64: memory-ack watchdog limit in cycles. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-low.
- if_req  in  1  fetch request; held high with stable if_addr until if_valid.
- if_addr  in  32  fetch byte address, word aligned.
- if_rdata  out  32  fetched instruction; valid when if_valid=1.
- if_valid  out  1  fetch completion pulse.
- if_stall  out  1  if_req & ~if_valid.
- dm_req  in  1  data request; held high with stable addr/wdata/func3/we until dm_valid.
- dm_we  in  1  1 = store, 0 = load.
- dm_func3  in  3  RV32 load/store funct3.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data, right-aligned.
- dm_rdata  out  32  extended load result.
- dm_valid  out  1  data completion pulse.
- dm_err  out  1  misaligned-access flag; qualified by dm_valid.
- dm_stall  out  1  dm_req & ~dm_valid.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  word address: {addr[31:2], 2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-steered store data.
- mem_rdata  in  32  memory read word; valid with mem_ack.
- mem_ack  in  1  single-cycle completion from memory.
- arb_timeout  out  1  sticky watchdog flag (tied 0 without ARB_TIMEOUT_EN).

Behaviour:
- FSM states:
  - IDLE
  - BUSY_IF
  - BUSY_DM
  - DM_ERR
- Reset (rst=0 at clock edge): state = IDLE, burst count = 0, arb_timeout = 0. All outputs are 0 during and after reset until a grant.
- Reset mid-transaction abandons the transaction. The memory must tolerate mem_req dropping before ack.
- IDLE grant rules:
  - DM only requesting: DM wins.
  - IF only requesting: IF wins.
  - Both requesting: DM wins unless burst count == MAX_DM_BURST, in which case IF wins.
- Burst count:
  - Increments on each DM grant made while if_req=1.
  - Clears on any IF grant, and on any DM grant made while if_req=0.
- DM grant, misaligned access:
  - Misaligned means half access with addr[0]=1, or word access with addr[1:0]!=0.
  - Next state is DM_ERR; no memory access is made.
  - DM_ERR lasts one cycle, asserts dm_valid=1 and dm_err=1, then returns to IDLE.
- DM grant, aligned access: next state BUSY_DM.
- IF grant: next state BUSY_IF.
- BUSY_x:
  - mem_req=1. mem_addr, mem_we, mem_be and mem_wdata are driven combinationally from the granted requester's held inputs.
  - For IF: mem_we=0, mem_be=4'hF.
- Ack handling:
  - On a cycle with mem_ack=1, the granted requester's valid is asserted combinationally in that same cycle, and rdata is combinational from mem_rdata.
  - Next state is IDLE.
  - The requester must drop req (or present a new one) on the following cycle.
- Latency:
  - Request seen in IDLE at edge t gives mem_req=1 from cycle t+1.
  - Ack at cycle t+k gives the valid pulse at t+k.
  - There is one mandatory IDLE cycle between transactions.
- Store steering (dm_func3):
  - sb: be = 1<<addr[1:0]; wdata byte replicated ×4.
  - sh: be = 4'b0011 << addr[1:0]; wdata half replicated ×2.
  - sw: be = 4'hF.
- Load extraction:
  - lb / lbu: select byte addr[1:0]; sign-extend (lb) or zero-extend (lbu).
  - lh / lhu: select half addr[1]; sign-extend (lh) or zero-extend (lhu).
  - lw: pass the word through.
- Unsupported func3 is treated as word access.
- mem_ack while in IDLE or DM_ERR is ignored.
- Outputs not qualified by valid are 0 when not in a BUSY state.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A cycle counter runs while in BUSY_x.
  - When it reaches TIMEOUT without mem_ack, the FSM returns to IDLE and completes the granted requester with valid=1 and rdata=0.
  - For DM the completion also sets dm_err=1.
  - arb_timeout is set and stays set until reset.
  - The counter clears on state exit.
- Undefined: no counter is built; BUSY waits indefinitely; arb_timeout is tied to 0.

Test Plan:
- Reset: hold rst=0 for 3 cycles with if_req=1 → mem_req=0 and all valids 0. After release, mem_req=1 on the second cycle.
- IF fetch: if_addr=0x100, memory acks after 3 cycles with 0x00500093 → if_valid pulses in the ack cycle with if_rdata=0x00500093; if_stall is high for the 3 cycles before the ack.
- Load extension: memory word 0x80FF7F01.
  - lb @0x203 → 0xFFFFFF80.
  - lbu @0x203 → 0x00000080.
  - lh @0x202 → 0xFFFF80FF.
  - lhu @0x200 → 0x00007F01.
- Stores:
  - sb 0xAB @0x301 → mem_be=0010, mem_wdata=0xABABABAB, mem_addr=0x300.
  - sh 0x1234 @0x302 → mem_be=1100.
  - sh @0x301 → dm_valid+dm_err after 1 cycle in DM_ERR, with mem_req never asserted.
- Contention: if_req and dm_req held continuously, MAX_DM_BURST=4 → grant sequence DM,DM,DM,DM,IF,DM… with one IDLE cycle between transactions.
- ARB_TIMEOUT_EN, TIMEOUT=64, DM load with no ack → after 64 BUSY cycles: dm_valid=1, dm_err=1, dm_rdata=0, arb_timeout=1 (sticky until rst=0).
